// File: rtl/grid_pkg.sv
// Shared types, grid geometry and packed-bus helpers for the grid arbiter.
// Cell codes, coordinate widths, arbiter state encoding.
package grid_pkg;

  typedef enum logic [2:0] {
    AIR   = 3'd0,
    WALL  = 3'd1,
    ENEMY = 3'd4
  } cell_e;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int X_W = 6;
  localparam int Y_W = 5;
  localparam int D_W = 3;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_e;

  // LSB of slice idx in a packed bus of w-bit fields
  function automatic int lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/grid_arbiter_if.sv
// Requester bundle plus grid RAM port of the arbiter.
// slave: arbiter side; master: requesters and RAM side.
interface grid_arbiter_if
  import grid_pkg::*;
#(
  parameter int N_REQ = 3
) ();

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     gnt;
  logic [X_W*N_REQ-1:0] req_x;
  logic [Y_W*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]     req_write;
  logic [D_W*N_REQ-1:0] req_wdata;
  logic [D_W-1:0]       rd_data;
  logic [N_REQ-1:0]     rd_valid;
  logic [X_W-1:0]       grid_x;
  logic [Y_W-1:0]       grid_y;
  logic                 grid_write;
  logic [D_W-1:0]       grid_in;
  logic [D_W-1:0]       grid_out;

  modport slave (
    input  req, req_x, req_y,
    input  req_write, req_wdata,
    input  grid_out,
    output gnt, rd_data, rd_valid,
    output grid_x, grid_y,
    output grid_write, grid_in
  );

  modport master (
    output req, req_x, req_y,
    output req_write, req_wdata,
    output grid_out,
    input  gnt, rd_data, rd_valid,
    input  grid_x, grid_y,
    input  grid_write, grid_in
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set req at or after ptr.
// Ports: req, ptr in; one-hot win and valid out.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  always_comb begin
    int idx;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// Round-robin owner of the single grid RAM port, with hold limit.
// Ports: clock, reset (async low), bus (requesters + RAM port).
module grid_arbiter
  import grid_pkg::*;
#(
  parameter int              N_REQ     = 3,
  parameter int              MAX_HOLD  = 0,
  parameter int              GRID_W    = GRID_W_DEF,
  parameter int              GRID_H    = GRID_H_DEF,
  parameter logic [D_W-1:0]  OOB_VALUE = WALL
) (
  input logic           clock,
  input logic           reset,
  grid_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    own_idx, nxt_ptr, pick_ptr;
  logic [N_REQ-1:0] win;
  logic             win_vld;
  logic             act, others, rel;
  logic [X_W-1:0]   x_own;
  logic [Y_W-1:0]   y_own;
  logic [D_W-1:0]   d_own;
  logic             wr, in_rng;
  logic [N_REQ-1:0] rdv_q;
  logic             oob_q;

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt_q[i]) own_idx = PW'(i);
  end

  assign act    = |(gnt_q & bus.req);
  assign others = |(bus.req & ~gnt_q);
  assign rel    = !act ||
    ((MAX_HOLD != 0) && (hold_q == HOLD_TOP) && others);

  assign nxt_ptr  = (own_idx == PW'(N_REQ - 1)) ?
                    '0 : own_idx + 1'b1;
  // On release the search already starts past the old owner
  assign pick_ptr = (state_q == OWNED) ? nxt_ptr : ptr_q;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .win   (win),
    .valid (win_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d   = win;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (rel) begin
          ptr_d   = nxt_ptr;
          gnt_d   = win;
          hold_d  = '0;
          state_d = win_vld ? OWNED : IDLE;
        end else if (others && hold_q != HOLD_TOP) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign x_own  = bus.req_x[lsb(int'(own_idx), X_W) +: X_W];
  assign y_own  = bus.req_y[lsb(int'(own_idx), Y_W) +: Y_W];
  assign d_own  = bus.req_wdata[lsb(int'(own_idx), D_W) +: D_W];
  assign wr     = bus.req_write[own_idx];
  assign in_rng = (int'(x_own) < GRID_W) &&
                  (int'(y_own) < GRID_H);

  assign bus.gnt        = gnt_q;
  assign bus.grid_x     = act ? x_own : '0;
  assign bus.grid_y     = act ? y_own : '0;
  assign bus.grid_in    = act ? d_own : '0;
  assign bus.grid_write = act & wr & in_rng;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdv_q <= '0;
      oob_q <= 1'b0;
    end else begin
      rdv_q <= (act && !wr) ? gnt_q : '0;
      oob_q <= !in_rng;
    end
  end

  // RAM output is only meaningful behind a strobe
  assign bus.rd_valid = rdv_q;
  assign bus.rd_data  = !(|rdv_q) ? '0 :
                        oob_q ? OOB_VALUE : bus.grid_out;

endmodule

// File: tb/tb_grid_arbiter.sv
// Scoreboard bench for grid_arbiter (hold limit 4 plus unlimited copy).
// Timed expectations and read returns checked by a negedge monitor.
module tb_grid_arbiter;
  import grid_pkg::*;

  localparam int K_GNT  = 0;
  localparam int K_GWR  = 1;
  localparam int K_RDV  = 2;
  localparam int K_RDD  = 3;
  localparam int K_GNTB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  grid_arbiter_if #(.N_REQ(3)) ifa ();
  grid_arbiter_if #(.N_REQ(3)) ifb ();

  grid_arbiter #(
    .N_REQ(3), .MAX_HOLD(4), .GRID_W(40),
    .GRID_H(30), .OOB_VALUE(3'd1)
  ) dut (
    .clock(clock), .reset(reset), .bus(ifa.slave)
  );

  grid_arbiter #(
    .N_REQ(3), .MAX_HOLD(0), .GRID_W(40),
    .GRID_H(30), .OOB_VALUE(3'd1)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave)
  );

  assign ifb.req       = ifa.req;
  assign ifb.req_x     = ifa.req_x;
  assign ifb.req_y     = ifa.req_y;
  assign ifb.req_write = ifa.req_write;
  assign ifb.req_wdata = ifa.req_wdata;
  assign ifb.grid_out  = '0;

  logic [2:0] mem [64][32];
  initial begin
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++)
        mem[x][y] = AIR;
    ifa.grid_out = '0;
  end
  always @(posedge clock) begin
    if (ifa.grid_write)
      mem[ifa.grid_x][ifa.grid_y] <= ifa.grid_in;
    ifa.grid_out <= mem[ifa.grid_x][ifa.grid_y];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         kind;
    logic [3:0] val;
    string      name;
  } tchk_t;

  typedef struct {
    int         at;
    logic [2:0] rdv;
    logic [2:0] rdd;
  } rchk_t;

  tchk_t tq[$];
  tchk_t keep[$];
  rchk_t rq[$];
  rchk_t r;
  logic [3:0] act;
  int errs = 0;
  int checks = 0;

  function automatic logic [3:0] probe(input int kind);
    case (kind)
      K_GNT:   return {1'b0, ifa.gnt};
      K_GWR:   return {3'b0, ifa.grid_write};
      K_RDV:   return {1'b0, ifa.rd_valid};
      K_RDD:   return {1'b0, ifa.rd_data};
      default: return {1'b0, ifb.gnt};
    endcase
  endfunction

  task automatic exp_at(input int dc, input int kind,
                        input logic [3:0] v, input string nm);
    tchk_t t;
    t.at = cyc + dc;
    t.kind = kind;
    t.val = v;
    t.name = nm;
    tq.push_back(t);
  endtask

  task automatic exp_rd(input logic [2:0] v, input logic [2:0] d);
    rchk_t e;
    e.at = cyc + 1;
    e.rdv = v;
    e.rdd = d;
    rq.push_back(e);
  endtask

  always @(negedge clock) begin
    keep = {};
    foreach (tq[i]) begin
      if (tq[i].at == cyc) begin
        checks++;
        act = probe(tq[i].kind);
        if (act !== tq[i].val) begin
          errs++;
          $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                   tq[i].name, cyc, act, tq[i].val);
        end
      end else if (tq[i].at < cyc) begin
        checks++;
        errs++;
        $display("FAIL %s missed cyc=%0d", tq[i].name, tq[i].at);
      end else begin
        keep.push_back(tq[i]);
      end
    end
    tq = keep;
    if (ifa.rd_valid != '0) begin
      checks++;
      if (rq.size() == 0) begin
        errs++;
        $display("FAIL rd_unexp cyc=%0d got rdv=%b data=%0d",
                 cyc, ifa.rd_valid, ifa.rd_data);
      end else begin
        r = rq.pop_front();
        if (r.at != cyc || r.rdv !== ifa.rd_valid ||
            r.rdd !== ifa.rd_data) begin
          errs++;
          $display("FAIL rd cyc=%0d got rdv=%b data=%0d exp cyc=%0d rdv=%b data=%0d",
                   cyc, ifa.rd_valid, ifa.rd_data, r.at, r.rdv, r.rdd);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rq(input int i, input int x, input int y,
                        input logic w, input int d);
    ifa.req_x[i*X_W +: X_W]     = X_W'(x);
    ifa.req_y[i*Y_W +: Y_W]     = Y_W'(y);
    ifa.req_write[i]            = w;
    ifa.req_wdata[i*D_W +: D_W] = D_W'(d);
  endtask

  // Parked requesters issue dropped out-of-range writes only
  task automatic park(input int i);
    set_rq(i, 63, 0, 1'b1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq;
    ifa.req = '0;
    for (int i = 0; i < 3; i++) park(i);
    tick(2);
    exp_at(0, K_GNT, 4'd0, "rst_gnt");
    exp_at(0, K_GWR, 4'd0, "rst_gwr");
    exp_at(0, K_RDV, 4'd0, "rst_rdv");
    exp_at(0, K_RDD, 4'd0, "rst_rdd");
    exp_at(0, K_GNTB, 4'd0, "rst_gntb");
    tick(1);
    reset = 1'b1;
    tick(1);

    ifa.req = 3'b101;
    exp_at(1, K_GNT, 4'b0001, "grant_first");
    exp_at(1, K_GNTB, 4'b0001, "grant_first_b");
    tick(1);
    exp_at(0, K_GNT, 4'b0001, "grant_held");
    ifa.req = 3'b100;
    exp_at(1, K_GNT, 4'b0100, "handover");
    exp_at(1, K_GNTB, 4'b0100, "handover_b");
    tick(1);
    ifa.req = 3'b000;
    exp_at(1, K_GNT, 4'd0, "to_idle1");
    tick(2);

    ifa.req = 3'b111;
    for (int c = 1; c <= 13; c++) begin
      seq = (c <= 4) ? 4'b0001 : (c <= 8) ? 4'b0010 :
            (c <= 12) ? 4'b0100 : 4'b0001;
      exp_at(c, K_GNT, seq, "rotate");
      exp_at(c, K_GNTB, 4'b0001, "no_limit_b");
    end
    tick(13);
    ifa.req = 3'b000;
    exp_at(1, K_GNT, 4'd0, "to_idle2");
    tick(2);

    ifa.req = 3'b100;
    for (int c = 1; c <= 20; c++) begin
      exp_at(c, K_GNT, 4'b0100, "lone_hold");
      exp_at(c, K_GNTB, 4'b0100, "lone_hold_b");
    end
    tick(20);
    ifa.req = 3'b000;
    exp_at(1, K_GNT, 4'd0, "to_idle3");
    tick(2);

    ifa.req = 3'b010;
    set_rq(1, 12, 7, 1'b1, 4);
    exp_at(1, K_GNT, 4'b0010, "grant_r1");
    exp_at(1, K_GWR, 4'd1, "write_in");
    tick(2);
    set_rq(1, 12, 7, 1'b0, 0);
    exp_at(0, K_GWR, 4'd0, "read_nowr");
    exp_rd(3'b010, 3'd4);
    tick(1);
    ifa.req = 3'b000;
    park(1);
    exp_at(1, K_GNT, 4'd0, "to_idle4");
    tick(2);

    ifa.req = 3'b001;
    set_rq(0, 40, 3, 1'b1, 4);
    exp_at(1, K_GNT, 4'b0001, "grant_r0");
    exp_at(1, K_GWR, 4'd0, "oob_write");
    tick(1);
    set_rq(0, 5, 30, 1'b0, 0);
    exp_at(0, K_GWR, 4'd0, "oob_read_nowr");
    exp_rd(3'b001, 3'd1);
    tick(1);
    set_rq(0, 39, 29, 1'b0, 0);
    exp_rd(3'b001, 3'd0);
    tick(1);
    ifa.req = 3'b000;
    park(0);
    exp_at(1, K_GNT, 4'd0, "to_idle5");
    tick(2);

    ifa.req = 3'b100;
    set_rq(2, 3, 3, 1'b0, 0);
    exp_at(1, K_GNT, 4'b0100, "grant_r2");
    tick(2);
    set_rq(2, 3, 3, 1'b1, 4);
    #1;
    reset = 1'b0;
    exp_at(0, K_GNT, 4'd0, "mid_rst_gnt");
    exp_at(0, K_RDV, 4'd0, "mid_rst_rdv");
    exp_at(0, K_GWR, 4'd0, "mid_rst_gwr");
    exp_at(0, K_RDD, 4'd0, "mid_rst_rdd");
    tick(1);
    park(2);
    ifa.req = 3'b000;
    reset = 1'b1;
    tick(1);
    ifa.req = 3'b110;
    exp_at(1, K_GNT, 4'b0010, "post_rst_grant");
    tick(1);
    ifa.req = 3'b000;
    exp_at(1, K_GNT, 4'd0, "to_idle6");
    tick(3);

    foreach (tq[i]) begin
      checks++;
      errs++;
      $display("FAIL %s never checked", tq[i].name);
    end
    foreach (rq[i]) begin
      checks++;
      errs++;
      $display("FAIL rd_missing exp cyc=%0d rdv=%b", rq[i].at, rq[i].rdv);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
